// File: rtl/sd2_pkg.sv
// Shared types for the SD2 second-order sigma-delta modulator.
package sd2_pkg;

    typedef enum logic {
        BS_NEG = 1'b0,
        BS_POS = 1'b1
    } bs_level_e;

endpackage

// File: rtl/sd2_sat_add.sv
// Signed W-bit three-operand adder (a + b - c) that clamps to the W-bit range.
module sd2_sat_add #(
    parameter int W = 20
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    input  logic signed [W:0]   c_i,
    output logic signed [W-1:0] sum_o
);

    localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

    logic signed [W+1:0] sumWide;

    // Two guard bits are enough to hold any a + b - c without wrapping.
    assign sumWide = {{2{a_i[W-1]}}, a_i} + {{2{b_i[W-1]}}, b_i} - {c_i[W], c_i};

    always_comb begin
        sum_o = sumWide[W-1:0];
        if (sumWide > MAX_V) begin
            sum_o = MAX_V[W-1:0];
        end else if (sumWide < MIN_V) begin
            sum_o = MIN_V[W-1:0];
        end
    end

endmodule

// File: rtl/sd2.sv
// Second-order CIFB sigma-delta modulator: two saturating integrators and a
// 1-bit quantizer taken from the registered second integrator.
module sd2
    import sd2_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [BW-1:0] sd_in,
    output logic                 bs_out
);

    localparam int W = BW + 4;
    localparam logic signed [W:0] FB_POS = {{(W+1-BW){1'b0}}, 1'b1, {(BW-1){1'b0}}};
    localparam logic signed [W:0] FB_NEG = {{(W+1-BW){1'b1}}, 1'b1, {(BW-1){1'b0}}};

    logic signed [W-1:0] int1_q;
    logic signed [W-1:0] int1_d;
    logic signed [W-1:0] int2_q;
    logic signed [W-1:0] int2_d;
    logic signed [W-1:0] sdExt;
    logic signed [W:0]   fb;
    bs_level_e           level;

    // Quantizer looks only at registered state, so sd_in never reaches bs_out combinationally.
    assign level  = int2_q[W-1] ? BS_NEG : BS_POS;
    assign bs_out = (level == BS_POS);
    assign fb     = (level == BS_POS) ? FB_POS : FB_NEG;
    assign sdExt  = {{(W-BW){sd_in[BW-1]}}, sd_in};

    sd2_sat_add #(.W(W)) u_add1 (
        .a_i   (int1_q),
        .b_i   (sdExt),
        .c_i   (fb),
        .sum_o (int1_d)
    );

    sd2_sat_add #(.W(W)) u_add2 (
        .a_i   (int2_q),
        .b_i   (int1_q),
        .c_i   (fb),
        .sum_o (int2_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_q <= '0;
            int2_q <= '0;
        end else begin
            int1_q <= int1_d;
            int2_q <= int2_d;
        end
    end

endmodule

// File: tb/tb_sd2.sv
// Self-checking bench for sd2: scoreboard of a cycle-accurate integrator model
// plus fixed-sequence, density, full-scale and asynchronous-reset scenarios.
`timescale 1ns/1ps
module tb_sd2;

    localparam int     BW    = 16;
    localparam int     W     = BW + 4;
    localparam int     FS    = 1 << (BW - 1);
    localparam longint MAX_V = (longint'(1) << (W - 1)) - 1;
    localparam longint MIN_V = -(longint'(1) << (W - 1));

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [BW-1:0] sd_in = '0;
    logic                 bs_out;

    sd2 #(.BW(BW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sd_in  (sd_in),
        .bs_out (bs_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic bs;
        int   i1;
        int   i2;
    } expect_t;

    expect_t sbQueue[$];
    int      modelInt1 = 0;
    int      modelInt2 = 0;
    int      total     = 0;
    int      bad       = 0;

    logic expBsSeq   [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int   expInt2Seq [0:3] = '{-32768, -32768, 0, 0};

    function automatic int satW(input longint s);
        if (s > MAX_V) return int'(MAX_V);
        if (s < MIN_V) return int'(MIN_V);
        return int'(s);
    endfunction

    // Called between edges: applies x, advances the model by one edge, waits past the edge.
    task automatic drive(input int x);
        expect_t e;
        int      fbVal;
        sd_in = x[BW-1:0];
        fbVal = (modelInt2 >= 0) ? FS : -FS;
        e.i1  = satW(longint'(modelInt1) + longint'(x) - longint'(fbVal));
        e.i2  = satW(longint'(modelInt2) + longint'(modelInt1) - longint'(fbVal));
        e.bs  = (e.i2 >= 0);
        modelInt1 = e.i1;
        modelInt2 = e.i2;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        sd_in     = '0;
        modelInt1 = 0;
        modelInt2 = 0;
        sbQueue.delete();
    endtask

    task automatic test_reset();
        int obs1;
        int obs2;
        rst_n = 1'b0;
        sd_in = 16'sd1234;
        repeat (3) @(posedge clk);
        #1;
        obs1 = dut.int1_q;
        obs2 = dut.int2_q;
        total++;
        if (bs_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_bs got=%b exp=1", bs_out);
        end
        total++;
        if (obs1 !== 0) begin
            bad++;
            $display("[TB] FAIL reset_int1 got=%0d exp=0", obs1);
        end
        total++;
        if (obs2 !== 0) begin
            bad++;
            $display("[TB] FAIL reset_int2 got=%0d exp=0", obs2);
        end
        rst_n     = 1'b1;
        sd_in     = '0;
        modelInt1 = 0;
        modelInt2 = 0;
        sbQueue.delete();
    endtask

    task automatic test_zero_input();
        expect_t e;
        int      obs1;
        int      obs2;
        pulse_reset();
        for (int k = 1; k <= 16; k++) begin
            drive(0);
            e    = sbQueue.pop_front();
            obs1 = dut.int1_q;
            obs2 = dut.int2_q;
            total++;
            if (bs_out !== expBsSeq[k % 8]) begin
                bad++;
                $display("[TB] FAIL zero_bs edge=%0d got=%b exp=%b", k, bs_out, expBsSeq[k % 8]);
            end
            total++;
            if (obs2 !== expInt2Seq[(k - 1) % 4]) begin
                bad++;
                $display("[TB] FAIL zero_int2 edge=%0d got=%0d exp=%0d", k, obs2, expInt2Seq[(k - 1) % 4]);
            end
            total++;
            if (obs1 !== e.i1) begin
                bad++;
                $display("[TB] FAIL zero_int1 edge=%0d got=%0d exp=%0d", k, obs1, e.i1);
            end
        end
    endtask

    task automatic test_density(input int x, input int lo, input int hi);
        expect_t e;
        int      ones = 0;
        pulse_reset();
        for (int k = 0; k < 4096; k++) begin
            drive(x);
            e = sbQueue.pop_front();
            if (bs_out === 1'b1) ones++;
            total++;
            if (bs_out !== e.bs) begin
                bad++;
                $display("[TB] FAIL density_bs x=%0d cyc=%0d got=%b exp=%b", x, k, bs_out, e.bs);
            end
        end
        total++;
        if (ones < lo || ones > hi) begin
            bad++;
            $display("[TB] FAIL density_ones x=%0d got=%0d exp=%0d..%0d", x, ones, lo, hi);
        end
    endtask

    task automatic test_full_scale();
        expect_t e;
        int      obs1;
        int      obs2;
        int      ones;
        int      phase;
        int      sdVal;
        int      len;
        pulse_reset();
        // Phases: positive full scale, recovery, measured zero window, then negative full scale.
        for (phase = 0; phase < 4; phase++) begin
            case (phase)
                0:       begin sdVal = FS - 1; len = 10000; end
                1:       begin sdVal = 0;      len = 512;   end
                2:       begin sdVal = 0;      len = 1024;  end
                default: begin pulse_reset(); sdVal = -FS; len = 2000; end
            endcase
            ones = 0;
            for (int k = 0; k < len; k++) begin
                drive(sdVal);
                e    = sbQueue.pop_front();
                obs1 = dut.int1_q;
                obs2 = dut.int2_q;
                if (bs_out === 1'b1) ones++;
                total++;
                if (bs_out !== e.bs || obs1 !== e.i1 || obs2 !== e.i2) begin
                    bad++;
                    $display("[TB] FAIL fullscale_state ph=%0d cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d",
                             phase, k, bs_out, obs1, obs2, e.bs, e.i1, e.i2);
                end
            end
            if (phase == 0) begin
                total++;
                if (ones < 9900) begin
                    bad++;
                    $display("[TB] FAIL fullscale_pos_ones got=%0d exp>=9900", ones);
                end
            end else if (phase == 2) begin
                total++;
                if (ones < 502 || ones > 522) begin
                    bad++;
                    $display("[TB] FAIL recovery_ones got=%0d exp=502..522", ones);
                end
            end else if (phase == 3) begin
                total++;
                if (ones > 20) begin
                    bad++;
                    $display("[TB] FAIL fullscale_neg_ones got=%0d exp<=20", ones);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        expect_t e;
        int      obs1;
        int      obs2;
        pulse_reset();
        for (int k = 0; k < 37; k++) begin
            drive(int'($urandom_range(0, 65535)) - FS);
            void'(sbQueue.pop_front());
        end
        #2 rst_n = 1'b0;
        #1;
        obs1 = dut.int1_q;
        obs2 = dut.int2_q;
        total++;
        if (bs_out !== 1'b1 || obs1 !== 0 || obs2 !== 0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%b/%0d/%0d exp=1/0/0", bs_out, obs1, obs2);
        end
        rst_n     = 1'b1;
        modelInt1 = 0;
        modelInt2 = 0;
        sbQueue.delete();
        for (int k = 1; k <= 7; k++) begin
            drive(0);
            e    = sbQueue.pop_front();
            obs2 = dut.int2_q;
            total++;
            if (bs_out !== expBsSeq[k]) begin
                bad++;
                $display("[TB] FAIL post_reset_bs edge=%0d got=%b exp=%b", k, bs_out, expBsSeq[k]);
            end
            total++;
            if (obs2 !== e.i2) begin
                bad++;
                $display("[TB] FAIL post_reset_int2 edge=%0d got=%0d exp=%0d", k, obs2, e.i2);
            end
        end
    endtask

    task automatic test_back_to_back();
        expect_t e;
        int      obs1;
        int      obs2;
        int      x;
        pulse_reset();
        for (int k = 0; k < 30000; k++) begin
            x = int'($urandom_range(0, 65535)) - FS;
            if ($urandom_range(0, 15) == 0) x = ($urandom_range(0, 1) == 0) ? -FS : FS - 1;
            drive(x);
            e    = sbQueue.pop_front();
            obs1 = dut.int1_q;
            obs2 = dut.int2_q;
            total++;
            if (bs_out !== e.bs) begin
                bad++;
                $display("[TB] FAIL random_bs cyc=%0d got=%b exp=%b", k, bs_out, e.bs);
            end
            total++;
            if (obs1 !== e.i1 || obs2 !== e.i2) begin
                bad++;
                $display("[TB] FAIL random_ints cyc=%0d got=%0d/%0d exp=%0d/%0d", k, obs1, obs2, e.i1, e.i2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_input();
        test_density(16384, 3056, 3088);
        test_density(-16384, 1008, 1040);
        test_full_scale();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
